sram_ctrl: RTL and testbench
============================

# sram_ctrl

Multi-cycle controller that sequences the MEM stage's single data-memory port onto an external 16-bit asynchronous SRAM. It accepts one 32-bit load or store per transaction from the MEM stage, splits it into two 16-bit SRAM accesses with programmable wait states, and drives `ready` low to freeze the pipeline until the access completes. It sits between the MEM stage and the SRAM pins; the MEM stage register captures `rdata` when `ready` is high.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: SRAM cycles held per 16-bit half; legal range 1..15.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `MEM_R_EN` in 1: load request, held stable until `ready`.
- `MEM_W_EN` in 1: store request, held stable until `ready`.
- `ALU_Res` in 32: byte address; bits [1:0] ignored.
- `Val_Rm` in 32: store data.
- `ready` out 1: high = pipeline may advance.
- `rdata` out 32: load result.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_WE_N` out 1: SRAM write strobe, active-low.
- `SRAM_DQ_OUT` out 16: data driven to SRAM.
- `SRAM_DQ_OE` out 1: enables the top-level tristate driver for `SRAM_DQ_OUT`.
- `SRAM_DQ_IN` in 16: data sampled from SRAM.

## Operation
- Word address `wa = (ALU_Res - BASE_ADDR) >> 2`, truncated to 17 bits. Low half goes to `{wa,1'b0}`, high half to `{wa,1'b1}`. Subtraction is modulo 2^32 with no range check.
- When `MEM_R_EN` and `MEM_W_EN` are both high, the access is a read and the write is ignored.
- State `IDLE`:
  - With no request, `ready`=1.
  - With a request, `ready`=0 and the state moves to `LO`.
  - Address, data and direction are latched on that edge.
- State `LO`:
  - `SRAM_ADDR` = low-half address.
  - For a write, `SRAM_DQ_OE`=1, `SRAM_DQ_OUT`=data[15:0], `SRAM_WE_N`=0.
  - The wait counter runs 0..`WAIT_CYCLES`-1. On the last count a read captures `SRAM_DQ_IN` into `rdata[15:0]`, and the state moves to `HI`.
- State `HI`: same as `LO`, using the high-half address and data[31:16]; captures into `rdata[31:16]`, then moves to `DONE`.
- State `DONE`: `ready`=1 for exactly one cycle, then unconditionally `IDLE`.
- `rdata` is registered and holds its value until the next read's captures. A write never alters `rdata`.
- `SRAM_WE_N`=1 and `SRAM_DQ_OE`=0 in `IDLE` and `DONE`, and for reads in every state. `SRAM_ADDR` holds its last value in `IDLE`.

## Timing
- Reset values:
  - state `IDLE`, counter 0, `ready`=1, `rdata`=0.
  - `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_DQ_OUT`=0, `SRAM_DQ_OE`=0.
- Request seen in cycle 0:
  - `LO` occupies cycles 1..W and `HI` occupies cycles W+1..2W.
  - `ready`=1 in cycle 2W+1, so the stall is 2W+1 cycles (5 at W=2).
- `ready` in `IDLE` is combinational from `MEM_R_EN|MEM_W_EN`. Every other output is decoded from registered state only.
- Back-to-back requests: the request after `DONE` is seen in `IDLE` on the next cycle. There is no dead cycle beyond `DONE`.
- Reset asserted mid-access:
  - The block returns immediately to `IDLE` with `SRAM_WE_N`=1 and `SRAM_DQ_OE`=0.
  - The partial write is abandoned; `rdata`=0.

## Configuration
- `SRAM_CTRL_WR_BUF_EN` defined:
  - Adds a one-entry posted-write buffer. A store seen in `IDLE` with the buffer empty gets `ready`=1 in the same cycle; the data is latched on that edge.
  - The buffer then drains through `LO`/`HI` and returns to `IDLE` without entering `DONE`.
  - Any request arriving while the buffer drains sees `ready`=0 until the drain completes, then proceeds normally. No read can overtake the buffered write.
- `SRAM_CTRL_WR_BUF_EN` undefined: stores stall like loads, and no buffer logic is present.

## Structure
- `sram_ctrl_pkg`: state enum (`IDLE`, `LO`, `HI`, `DONE`), `BASE_ADDR` default, `SRAM_AW`=18, `SRAM_DW`=16.
- One sub-module, `sram_wait_cnt`: a 4-bit counter with load, enable and a `last` flag compared against `WAIT_CYCLES`-1.

## Test plan
- Reset: after `rst` is released, all outputs equal their reset values and `ready`=1 with no request.
- Store `ALU_Res`=1028, `Val_Rm`=0xDEADBEEF, W=2:
  - `SRAM_ADDR`=2 with `SRAM_DQ_OUT`=0xBEEF for 2 cycles, then `SRAM_ADDR`=3 with 0xDEAD for 2 cycles.
  - `ready`=1 in cycle 5.
- Load from 1028 with a SRAM model preloaded as above: `rdata`=0xDEADBEEF in cycle 5, and `SRAM_WE_N` stays 1 throughout.
- Both enables high at 1032: the access executes as a read, and `SRAM_WE_N` never goes low.
- `rst` pulsed during `HI` of a store: `SRAM_WE_N` returns to 1 asynchronously, and the next request starts cleanly from `LO`.
- With `SRAM_CTRL_WR_BUF_EN` defined, a store followed immediately by a load:
  - The store gets `ready`=1 in cycle 0.
  - The load stalls until the drain finishes, then returns the stored value.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_AW       = 18;
    localparam int SRAM_DW       = 16;
    localparam int WA_W          = 17;
    localparam int DEF_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Byte address to 32-bit word offset inside the SRAM window (modulo, no range check).
    function automatic logic [WA_W-1:0] word_addr(input logic [31:0] byte_addr,
                                                  input logic [31:0] base);
        logic [31:0] diff;
        diff = byte_addr - base;
        return diff[18:2];
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Wait-state counter: clears on load, counts on enable, flags the final wait cycle.
module sram_wait_cnt #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 4'd0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit MEM-stage accesses into two 16-bit async-SRAM accesses with wait states.
// Optional posted-write buffer enabled by defining SRAM_CTRL_WR_BUF_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MEM_R_EN,
    input  logic                 MEM_W_EN,
    input  logic [31:0]          ALU_Res,
    input  logic [31:0]          Val_Rm,
    output logic                 ready,
    output logic [31:0]          rdata,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic [SRAM_DW-1:0]   SRAM_DQ_OUT,
    output logic                 SRAM_DQ_OE,
    input  logic [SRAM_DW-1:0]   SRAM_DQ_IN
);

    state_e              state_q, state_d;
    logic [WA_W-1:0]     wa_q, wa_d;
    logic [31:0]         data_q, data_d;
    logic                wr_q, wr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
    logic                we_n_q, we_n_d;
    logic [SRAM_DW-1:0]  dq_out_q, dq_out_d;
    logic                oe_q, oe_d;
    logic                cnt_load, cnt_en, cnt_last;
    logic                req, wr_req;
`ifdef SRAM_CTRL_WR_BUF_EN
    logic                posted_q, posted_d;
`endif

    assign req    = MEM_R_EN | MEM_W_EN;
    assign wr_req = MEM_W_EN & ~MEM_R_EN;

    sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .last (cnt_last)
    );

    // Next-state, request latching, read capture and ready
    always_comb begin
        state_d  = state_q;
        wa_d     = wa_q;
        data_d   = data_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        ready    = 1'b0;
`ifdef SRAM_CTRL_WR_BUF_EN
        posted_d = posted_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_load = 1'b1;
                if (req) begin
                    state_d = LO;
                    wa_d    = word_addr(ALU_Res, 32'(BASE_ADDR));
                    data_d  = Val_Rm;
                    wr_d    = wr_req;
`ifdef SRAM_CTRL_WR_BUF_EN
                    posted_d = wr_req;
                    ready    = wr_req;
`else
                    ready    = 1'b0;
`endif
                end else begin
                    ready = 1'b1;
                end
            end
            LO: begin
                if (cnt_last) begin
                    cnt_load = 1'b1;
                    state_d  = HI;
                    if (!wr_q) begin
                        rdata_d[15:0] = SRAM_DQ_IN;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HI: begin
                if (cnt_last) begin
                    cnt_load = 1'b1;
                    if (!wr_q) begin
                        rdata_d[31:16] = SRAM_DQ_IN;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef SRAM_CTRL_WR_BUF_EN
                    // A posted store already released the pipeline, so skip DONE.
                    state_d  = posted_q ? IDLE : DONE;
                    posted_d = 1'b0;
`else
                    state_d  = DONE;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pin values for the upcoming state, so pins are plain flops
    always_comb begin
        sram_addr_d = sram_addr_q;
        we_n_d      = 1'b1;
        oe_d        = 1'b0;
        dq_out_d    = dq_out_q;
        case (state_d)
            LO, HI: begin
                sram_addr_d = {wa_d, (state_d == HI)};
                if (wr_d) begin
                    we_n_d   = 1'b0;
                    oe_d     = 1'b1;
                    dq_out_d = (state_d == HI) ? data_d[31:16] : data_d[15:0];
                end else begin
                    we_n_d = 1'b1;
                end
            end
            default: begin
                we_n_d = 1'b1;
            end
        endcase
    end

    // State, latched request and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wa_q        <= '0;
            data_q      <= 32'd0;
            wr_q        <= 1'b0;
            rdata_q     <= 32'd0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
`ifdef SRAM_CTRL_WR_BUF_EN
            posted_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wa_q        <= wa_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
`ifdef SRAM_CTRL_WR_BUF_EN
            posted_q    <= posted_d;
`endif
        end
    end

    assign rdata       = rdata_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_DQ_OUT = dq_out_q;
    assign SRAM_DQ_OE  = oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a small behavioural async SRAM.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_WR_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif
    localparam int STORE_DROP = BUF ? 1 : 5;
    localparam int NC = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] ALU_Res = 32'd0;
    logic [31:0] Val_Rm = 32'd0;
    logic        ready;
    logic [31:0] rdata;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE;
    logic [15:0] SRAM_DQ_IN;

    logic [15:0] mem [0:15];

    int n_checks = 0;
    int n_errors = 0;

    logic        obs_ready [0:NC-1];
    logic [31:0] obs_rdata [0:NC-1];
    logic [17:0] obs_addr  [0:NC-1];
    logic        obs_we_n  [0:NC-1];
    logic [15:0] obs_dq    [0:NC-1];
    logic        obs_oe    [0:NC-1];

    sram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .ALU_Res     (ALU_Res),
        .Val_Rm      (Val_Rm),
        .ready       (ready),
        .rdata       (rdata),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_DQ_IN  (SRAM_DQ_IN)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!SRAM_WE_N) mem[SRAM_ADDR[3:0]] <= SRAM_DQ_OUT;
    end
    assign SRAM_DQ_IN = mem[SRAM_ADDR[3:0]];

    // Drive one request (optionally switched at sw_k, dropped at drop_k) and record NC cycles.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input int drop_k, input int sw_k,
                              input logic r2, input logic w2, input logic [31:0] a2);
        @(negedge clk);
        MEM_R_EN = r; MEM_W_EN = w; ALU_Res = a; Val_Rm = d;
        for (int k = 0; k < NC; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            obs_ready[k] = ready;  obs_rdata[k] = rdata; obs_addr[k] = SRAM_ADDR;
            obs_we_n[k]  = SRAM_WE_N; obs_dq[k] = SRAM_DQ_OUT; obs_oe[k] = SRAM_DQ_OE;
            if (k == sw_k) begin
                MEM_R_EN = r2; MEM_W_EN = w2; ALU_Res = a2;
            end
            if (k == drop_k) begin
                MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
            end
        end
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks += 6;
        if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %0b want 1", ready); end
        if (rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        if (SRAM_ADDR !== 18'd0) begin n_errors++; $display("FAIL reset_addr got %h want 0", SRAM_ADDR); end
        if (SRAM_WE_N !== 1'b1) begin n_errors++; $display("FAIL reset_we_n got %0b want 1", SRAM_WE_N); end
        if (SRAM_DQ_OUT !== 16'd0) begin n_errors++; $display("FAIL reset_dq got %h want 0", SRAM_DQ_OUT); end
        if (SRAM_DQ_OE !== 1'b0) begin n_errors++; $display("FAIL reset_oe got %0b want 0", SRAM_DQ_OE); end
    endtask

    task automatic test_store();
        logic [17:0] ea;
        logic [15:0] ed;
        run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, STORE_DROP, -1, 1'b0, 1'b0, 32'd0);
        n_checks++;
        if (obs_ready[0] !== BUF) begin n_errors++; $display("FAIL store_ready_c0 got %0b want %0b", obs_ready[0], BUF); end
        for (int k = 1; k <= 4; k++) begin
            ea = (k <= 2) ? 18'd2 : 18'd3;
            ed = (k <= 2) ? 16'hBEEF : 16'hDEAD;
            n_checks += 5;
            if (obs_addr[k] !== ea) begin n_errors++; $display("FAIL store_addr c%0d got %h want %h", k, obs_addr[k], ea); end
            if (obs_dq[k] !== ed) begin n_errors++; $display("FAIL store_dq c%0d got %h want %h", k, obs_dq[k], ed); end
            if (obs_we_n[k] !== 1'b0) begin n_errors++; $display("FAIL store_we_n c%0d got %0b want 0", k, obs_we_n[k]); end
            if (obs_oe[k] !== 1'b1) begin n_errors++; $display("FAIL store_oe c%0d got %0b want 1", k, obs_oe[k]); end
            if (obs_ready[k] !== 1'b0) begin n_errors++; $display("FAIL store_ready c%0d got %0b want 0", k, obs_ready[k]); end
        end
        n_checks += 4;
        if (obs_ready[5] !== 1'b1) begin n_errors++; $display("FAIL store_ready_c5 got %0b want 1", obs_ready[5]); end
        if (obs_we_n[5] !== 1'b1) begin n_errors++; $display("FAIL store_we_n_c5 got %0b want 1", obs_we_n[5]); end
        if (obs_addr[6] !== 18'd3) begin n_errors++; $display("FAIL store_addr_hold got %h want 3", obs_addr[6]); end
        if (obs_rdata[6] !== 32'd0) begin n_errors++; $display("FAIL store_rdata_untouched got %h want 0", obs_rdata[6]); end
    endtask

    task automatic test_load();
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 5, -1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k <= 5; k++) begin
            n_checks += 3;
            if (obs_ready[k] !== (k == 5)) begin n_errors++; $display("FAIL load_ready c%0d got %0b want %0b", k, obs_ready[k], (k == 5)); end
            if (obs_we_n[k] !== 1'b1) begin n_errors++; $display("FAIL load_we_n c%0d got %0b want 1", k, obs_we_n[k]); end
            if (obs_oe[k] !== 1'b0) begin n_errors++; $display("FAIL load_oe c%0d got %0b want 0", k, obs_oe[k]); end
        end
        n_checks += 3;
        if (obs_addr[1] !== 18'd2) begin n_errors++; $display("FAIL load_addr_lo got %h want 2", obs_addr[1]); end
        if (obs_addr[3] !== 18'd3) begin n_errors++; $display("FAIL load_addr_hi got %h want 3", obs_addr[3]); end
        if (obs_rdata[5] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_rdata got %h want deadbeef", obs_rdata[5]); end
    endtask

    task automatic test_both_enables();
        run_access(1'b0, 1'b1, 32'd1032, 32'h12345678, STORE_DROP, -1, 1'b0, 1'b0, 32'd0);
        run_access(1'b1, 1'b1, 32'd1032, 32'hFFFFFFFF, 5, -1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < NC; k++) begin
            n_checks += 2;
            if (obs_we_n[k] !== 1'b1) begin n_errors++; $display("FAIL both_we_n c%0d got %0b want 1", k, obs_we_n[k]); end
            if (obs_oe[k] !== 1'b0) begin n_errors++; $display("FAIL both_oe c%0d got %0b want 0", k, obs_oe[k]); end
        end
        n_checks += 4;
        if (obs_ready[0] !== 1'b0) begin n_errors++; $display("FAIL both_ready_c0 got %0b want 0", obs_ready[0]); end
        if (obs_addr[1] !== 18'd4) begin n_errors++; $display("FAIL both_addr got %h want 4", obs_addr[1]); end
        if (obs_ready[5] !== 1'b1) begin n_errors++; $display("FAIL both_ready_c5 got %0b want 1", obs_ready[5]); end
        if (obs_rdata[5] !== 32'h12345678) begin n_errors++; $display("FAIL both_rdata got %h want 12345678", obs_rdata[5]); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 11, 5, 1'b1, 1'b0, 32'd1032);
        n_checks += 6;
        if (obs_ready[5] !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_c5 got %0b want 1", obs_ready[5]); end
        if (obs_rdata[5] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_rdata1 got %h want deadbeef", obs_rdata[5]); end
        if (obs_ready[6] !== 1'b0) begin n_errors++; $display("FAIL b2b_ready_c6 got %0b want 0", obs_ready[6]); end
        if (obs_addr[7] !== 18'd4) begin n_errors++; $display("FAIL b2b_addr_c7 got %h want 4", obs_addr[7]); end
        if (obs_ready[10] !== 1'b0) begin n_errors++; $display("FAIL b2b_ready_c10 got %0b want 0", obs_ready[10]); end
        if (obs_rdata[11] !== 32'h12345678 || obs_ready[11] !== 1'b1) begin
            n_errors++; $display("FAIL b2b_second got rdata %h ready %0b want 12345678 1", obs_rdata[11], obs_ready[11]);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b1; ALU_Res = 32'd1036; Val_Rm = 32'hAAAA5555;
        repeat (3) @(negedge clk);
        #1;
        n_checks += 2;
        if (SRAM_WE_N !== 1'b0) begin n_errors++; $display("FAIL rstmid_pre_we_n got %0b want 0", SRAM_WE_N); end
        if (SRAM_ADDR !== 18'd7) begin n_errors++; $display("FAIL rstmid_pre_addr got %h want 7", SRAM_ADDR); end
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (SRAM_WE_N !== 1'b1) begin n_errors++; $display("FAIL rstmid_we_n got %0b want 1", SRAM_WE_N); end
        if (SRAM_DQ_OE !== 1'b0) begin n_errors++; $display("FAIL rstmid_oe got %0b want 0", SRAM_DQ_OE); end
        if (rdata !== 32'd0) begin n_errors++; $display("FAIL rstmid_rdata got %h want 0", rdata); end
        MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 5, -1, 1'b0, 1'b0, 32'd0);
        n_checks += 4;
        if (obs_ready[0] !== 1'b0) begin n_errors++; $display("FAIL rstmid_next_c0 got %0b want 0", obs_ready[0]); end
        if (obs_addr[1] !== 18'd2) begin n_errors++; $display("FAIL rstmid_next_addr got %h want 2", obs_addr[1]); end
        if (obs_ready[4] !== 1'b0 || obs_ready[5] !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_next_ready got c4 %0b c5 %0b want 0 1", obs_ready[4], obs_ready[5]);
        end
        if (obs_rdata[5] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rstmid_next_rdata got %h want deadbeef", obs_rdata[5]); end
    endtask

`ifdef SRAM_CTRL_WR_BUF_EN
    task automatic test_wr_buf();
        run_access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 10, 1, 1'b1, 1'b0, 32'd1040);
        n_checks += 5;
        if (obs_ready[0] !== 1'b1) begin n_errors++; $display("FAIL wbuf_ready_c0 got %0b want 1", obs_ready[0]); end
        if (obs_ready[4] !== 1'b0 || obs_ready[5] !== 1'b0) begin
            n_errors++; $display("FAIL wbuf_stall got c4 %0b c5 %0b want 0 0", obs_ready[4], obs_ready[5]);
        end
        if (obs_we_n[6] !== 1'b1 || obs_addr[6] !== 18'd8) begin
            n_errors++; $display("FAIL wbuf_load_lo got we_n %0b addr %h want 1 8", obs_we_n[6], obs_addr[6]);
        end
        if (obs_ready[10] !== 1'b1) begin n_errors++; $display("FAIL wbuf_ready_c10 got %0b want 1", obs_ready[10]); end
        if (obs_rdata[10] !== 32'hCAFEF00D) begin n_errors++; $display("FAIL wbuf_rdata got %h want cafef00d", obs_rdata[10]); end
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_both_enables();
        test_back_to_back();
        test_reset_mid_access();
`ifdef SRAM_CTRL_WR_BUF_EN
        test_wr_buf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
